// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants and FSM state type for the 7-segment scan controller.
package display_scan_ctrl_pkg;
  localparam logic [4:0] CODE_BLANK = 5'h1F;
  localparam logic [4:0] CODE_DASH  = 5'h10;
  localparam logic [6:0] SEG_OFF    = 7'h7F;

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } state_t;
endpackage

// File: rtl/display_scan_ctrl_display.sv
// Combinational 5-bit code to active-low 7-segment decoder, S = {g,f,e,d,c,b,a}.
module display
  import display_scan_ctrl_pkg::*;
(
  input  logic [4:0] x,
  output logic [6:0] S
);
  always_comb begin
    S = SEG_OFF;
    case (x)
      5'h00: S = 7'h40;
      5'h01: S = 7'h79;
      5'h02: S = 7'h24;
      5'h03: S = 7'h30;
      5'h04: S = 7'h19;
      5'h05: S = 7'h12;
      5'h06: S = 7'h02;
      5'h07: S = 7'h78;
      5'h08: S = 7'h00;
      5'h09: S = 7'h10;
      5'h0A: S = 7'h08;
      5'h0B: S = 7'h03;
      5'h0C: S = 7'h46;
      5'h0D: S = 7'h21;
      5'h0E: S = 7'h06;
      5'h0F: S = 7'h0E;
      CODE_DASH: S = 7'h3F;
      default: S = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller: guard/drive slots per digit, leading-zero
// blanking and per-digit blink, one shared decoder sampled at slot start.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYC    = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [4:0]                    wr_code,
  input  logic                          blank_lz,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         an,
  output logic                          frame_done,
  output state_t                        state
);
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int MAXC = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
  localparam int CW   = $clog2(MAXC);
  localparam int FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [4:0]      code_q [NUM_DIGITS];
  logic [FW-1:0]   fcnt_q;
  logic            phase_on;
  logic            slot_end;
  logic            lz_zero;
  logic [4:0]      eff_code;
  logic [6:0]      seg_dec;
  logic [NUM_DIGITS-1:0] an_drive;

  assign state = state_q;

  always_comb begin
    slot_end = (state_q == GUARD) ? (cnt_q == CW'(GUARD_CYC - 1))
                                  : (cnt_q == CW'(REFRESH_DIV - 1));
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) begin
      cnt_d = '0;
      if (state_q == GUARD) begin
        state_d = DRIVE;
      end else begin
        state_d = GUARD;
        idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
    end
  end

  // A digit is a leading zero when it and every more significant digit are 0.
  always_comb begin
    lz_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((IW'(j) >= idx_q) && (code_q[j] != 5'd0)) lz_zero = 1'b0;
    end
    eff_code = code_q[idx_q];
    if ((blank_lz && (idx_q != '0) && lz_zero) || (blink_mask[idx_q] && !phase_on))
      eff_code = CODE_BLANK;
    an_drive        = '1;
    an_drive[idx_q] = 1'b0;
  end

  display u_display (
    .x (eff_code),
    .S (seg_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= GUARD;
      cnt_q      <= '0;
      idx_q      <= '0;
      seg        <= SEG_OFF;
      an         <= '1;
      frame_done <= 1'b0;
      fcnt_q     <= '0;
      phase_on   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      frame_done <= 1'b0;
      if (slot_end) begin
        if (state_q == GUARD) begin
          seg <= seg_dec;
          an  <= an_drive;
        end else begin
          seg <= SEG_OFF;
          an  <= '1;
          // Blink state advances with the frame so the next digit 0 sees it.
          if (idx_q == IW'(NUM_DIGITS - 1)) begin
            frame_done <= 1'b1;
            if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
              fcnt_q   <= '0;
              phase_on <= ~phase_on;
            end else begin
              fcnt_q <= fcnt_q + 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) code_q[i] <= CODE_BLANK;
    end else if (wr_en && (int'(wr_addr) < NUM_DIGITS)) begin
      code_q[wr_addr] <= wr_code;
    end
  end
endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. It holds one 5-bit display code per digit and shares a single `display` decoder across all digits. Each digit is driven in turn, with a blanking guard interval between digits, optional leading-zero blanking and per-digit blink. It sits between the value-producing logic and the board's segment/anode pins.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned (2..8).
- `REFRESH_DIV`, 50000: clock cycles each digit is driven (≥2).
- `GUARD_CYC`, 500: cycles with all anodes off between digits (≥1).
- `BLINK_FRAMES`, 64: full scan frames per blink half-period (≥1).
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `wr_en`  in  1  write strobe for the digit code register.
- `wr_addr`  in  $clog2(NUM_DIGITS)  digit index; 0 = least significant.
- `wr_code`  in  5  decoder code: 0–15 hex digit, 16 dash, 17–31 blank.
- `blank_lz`  in  1  leading-zero blanking enable.
- `blink_mask`  in  NUM_DIGITS  digits that blink.
- `seg`  out  7  segments, active-low, bit order as `display.S`.
- `an`  out  NUM_DIGITS  anode enables, active-low, one-hot-low while driving.
- `frame_done`  out  1  one-cycle pulse at end of each full scan.

## Operation
- Code registers: `code[i]` are written when `wr_en` is high at the edge. A `wr_addr` ≥ NUM_DIGITS is ignored. Reset value is 5'h1F (blank).
- FSM with two states:
  - GUARD: `an` is all ones and `seg` = 7'h7F. After GUARD_CYC cycles the FSM moves to DRIVE.
  - DRIVE: `an[idx]`=0 and `seg` = decode(eff_code). After REFRESH_DIV cycles the FSM moves to GUARD and `idx` advances, wrapping from NUM_DIGITS-1 to 0.
- eff_code is 5'h1F when either condition holds, otherwise `code[idx]`:
  - Leading-zero blank: `blank_lz`=1, idx≠0, and `code[j]`==0 for all j ≥ idx.
  - Blink blank: `blink_mask[idx]`=1 and blink phase is OFF.
- eff_code is sampled on the GUARD→DRIVE edge. `seg` is held constant for the whole DRIVE slot. A write to the currently driven digit appears the next time that digit is driven. A write on the sampling edge is not seen; the old value is used.
- `frame_done` is high for the single cycle following the DRIVE→GUARD edge of digit NUM_DIGITS-1.
- Blink:
  - A frame counter increments on each `frame_done`.
  - On reaching BLINK_FRAMES it resets to 0 and toggles the phase.
  - Phase resets to ON (visible).
- `blank_lz` and `blink_mask` are sampled at the same edge as eff_code.

## Timing
- Reset values: `seg`=7'h7F, `an`=all ones, `frame_done`=0, FSM in GUARD with counter 0, `idx`=0, blink phase ON, frame counter 0.
- Reset asserted mid-slot forces all outputs to reset values immediately, asynchronously.
- `seg` and `an` are registered and change on the same edge; no glitch and no overlap between digits.
- The first DRIVE (digit 0) begins GUARD_CYC cycles after reset deasserts.
- Slot period is REFRESH_DIV+GUARD_CYC cycles. Frame period is NUM_DIGITS×(REFRESH_DIV+GUARD_CYC).
- Write latency to the pins is at most one frame period plus one slot.

## Structure
- Shared package holds:
  - blank code 5'h1F and dash code 5'h10;
  - SEG_OFF = 7'h7F;
  - FSM state typedef {GUARD, DRIVE}.
- Sub-module: a single instance of the existing combinational decoder `display` (.x = eff_code, .S = decoded segments). Its output is registered into `seg` at slot start.
- Counters are sized $clog2 of their max value; no other hierarchy.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYC=1, BLINK_FRAMES=2.
- Reset: hold `rst` → `seg`=7'h7F, `an`=4'hF. One cycle after release, digit 0 is driven: `an`=4'b1110, `seg`=7'b1111111.
- Write codes 0,8,9,7 to addr 0..3 → per slot: (1110,1000000), (1101,0000000), (1011,0010000), (0111,1111000). `frame_done` pulses once per 20 cycles.
- `blank_lz`=1 with codes {3:0, 2:0, 1:9, 0:0}:
  - digits 3 and 2 show 1111111, digit 1 shows 0010000, digit 0 shows 1000000.
  - With all codes 0, only digit 0 shows 1000000.
- Write code 16 to addr 2 mid-DRIVE of digit 2 → current slot keeps the old pattern. Next drive of digit 2 shows 0111111. Code 31 shows 1111111.
- `blink_mask`=4'b0001, code[0]=0 → digit 0 shows 1000000 for frames 0–1, 1111111 for frames 2–3, and repeats. Other digits are unaffected.
- Assert `rst` in the middle of a DRIVE slot → outputs go to 7'h7F/4'hF without waiting for a clock edge. All codes read back blank after release.
